pid_dispatch: RTL
=================

Name: pid_dispatch

Overview:
- Read-side consumer of the PID order FIFO.
- Pops one PID byte at a time, checks it, and classifies it.
- Presents each supported PID to the protocol controller over a valid/ready handshake.
- For DATA0/DATA1 it waits until the payload has been drained before popping the next PID. It also tracks the data toggle and keeps a saturating error count.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum number of cycles spent in WAIT_DATA before aborting.
- TO_BITS, 10: width of the timeout counter; must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous, active-high reset (1 = reset at the clk edge).
- fifo_empty  in  1  PID FIFO empty flag.
- fifo_r_data  in  8  FIFO head byte; first-word fall-through, valid whenever fifo_empty=0.
- fifo_r_enable  out  1  pop strobe; one byte is removed per cycle while high.
- token_valid  out  1  classified PID is being presented.
- token_type  out  3  0=OUT 1=IN 2=SETUP 3=DATA0 4=DATA1 5=ACK 6=NAK 7=STALL.
- token_ready  in  1  controller accepts the token on a cycle where valid and ready are both 1.
- data_done  in  1  payload for the last DATA PID is fully consumed.
- pid_error  out  1  one-cycle pulse: PID check failed.
- unsupported  out  1  one-cycle pulse: valid PID that is not dispatched (SOF, PRE/ERR, SPLIT, PING, NYET, MDATA, DATA2).
- seq_error  out  1  one-cycle pulse: DATA PID does not match the expected toggle.
- timeout  out  1  one-cycle pulse: WAIT_DATA expired.
- err_count  out  8  saturating count of pid_error and timeout events.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE, pid_reg=0, expected toggle=0, timeout counter=0.
  - Reset never pops the FIFO. Reset mid-operation abandons the current PID; err_count is cleared.
- FSM states are IDLE, DECODE, ISSUE, WAIT_DATA.
- IDLE:
  - If fifo_empty=0: latch fifo_r_data into pid_reg, assert fifo_r_enable for exactly this cycle, then go to DECODE.
  - Otherwise stay in IDLE; fifo_r_enable=0.
- DECODE (one cycle, no outputs except pulses):
  - Check: pid_reg[7:4] must equal ~pid_reg[3:0]. On failure pulse pid_error, increment err_count, go to IDLE.
  - Map by pid_reg[3:0]:
    - 0x1 OUT, 0x9 IN, 0xD SETUP.
    - 0x3 DATA0, 0xB DATA1.
    - 0x2 ACK, 0xA NAK, 0xE STALL.
  - A mapped PID loads token_type and goes to ISSUE.
  - Any other nibble pulses unsupported and goes to IDLE.
- ISSUE:
  - token_valid=1; token_type is held stable until accepted.
  - The FSM stays in ISSUE indefinitely while token_ready=0.
  - On acceptance, token_valid drops the next cycle.
  - After acceptance, DATA0/DATA1 go to WAIT_DATA; all other types go to IDLE.
- Data toggle:
  - Acceptance of SETUP sets expected=0.
  - Acceptance of DATA0/DATA1:
    - If the PID toggle bit (DATA1=1) equals expected, flip expected.
    - Otherwise pulse seq_error in the acceptance cycle and leave expected unchanged. The token is still issued.
- WAIT_DATA:
  - The timeout counter clears on entry and increments each cycle.
  - data_done=1 goes to IDLE.
  - If the count reaches TIMEOUT_CYCLES with data_done=0: pulse timeout, increment err_count, go to IDLE.
  - If data_done and expiry occur in the same cycle, data_done wins and no timeout is raised.
  - data_done is ignored in all other states.
- Latency: with the head present at cycle N (IDLE), the pop is at N, DECODE at N+1, token_valid at N+2. Best-case throughput is one non-data PID per 3 cycles.
- err_count:
  - Saturates at 255; no wrap.
  - If pid_error and timeout occur in the same cycle, increment by 1.
- fifo_r_enable is never asserted when fifo_empty=1. The FIFO is never popped outside IDLE.

Test Plan:
1. Reset, then push 0xE1 (OUT), hold token_ready=1 -> fifo_r_enable pulse at cycle N; token_valid=1 with token_type=0 at N+2 for exactly one cycle; FIFO empty afterwards.
2. Push 0x69 (IN) with token_ready=0 for 5 cycles, then 1 -> token_valid held high 6 cycles with token_type=1 stable; no further pop until return to IDLE.
3. Push 0x2D, then 0xC3, then 0x4B, with data_done pulsed 3 cycles into each WAIT_DATA -> types 2, 3, 4 issued; seq_error never asserted. Then push 0x4B again -> seq_error pulses at acceptance.
4. Push 0x11 (bad check), then 0xA5 (SOF) -> pid_error pulse with err_count=1; unsupported pulse with err_count still 1; token_valid stays 0.
5. Push 0xC3, accept it, never assert data_done -> timeout pulse exactly TIMEOUT_CYCLES cycles after entering WAIT_DATA; err_count increments; next PID is then popped.
6. Generate 300 bad PIDs -> err_count=255 and stays 255. Assert n_rst=1 while in ISSUE -> token_valid=0 next edge, err_count=0, FIFO contents unchanged.

Source files
------------

// File: rtl/pid_dispatch.sv
// pid_dispatch: pops PID bytes from the order FIFO, validates and classifies them,
// hands supported tokens to the protocol controller and tracks the DATA toggle.
module pid_dispatch #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_BITS        = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_r_enable,
    output logic       token_valid,
    output logic [2:0] token_type,
    input  logic       token_ready,
    input  logic       data_done,
    output logic       pid_error,
    output logic       unsupported,
    output logic       seq_error,
    output logic       timeout,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT_DATA} state_t;
    state_t state_q, state_d;
    logic [7:0] pid_q, pid_d;
    logic [2:0] type_q, type_d;
    logic exp_q, exp_d;
    logic [TO_BITS-1:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic chk_ok, mapped, accept, is_data, expired;
    logic [2:0] map_type;
    assign chk_ok  = pid_q[7:4] == ~pid_q[3:0];
    assign accept  = state_q == ISSUE && token_ready;
    assign is_data = type_q == 3'd3 || type_q == 3'd4;
    assign expired = cnt_q == TO_BITS'(TIMEOUT_CYCLES);
    always_comb begin
        mapped   = 1'b1;
        map_type = 3'd0;
        case (pid_q[3:0])
            4'h1:    map_type = 3'd0;
            4'h9:    map_type = 3'd1;
            4'hD:    map_type = 3'd2;
            4'h3:    map_type = 3'd3;
            4'hB:    map_type = 3'd4;
            4'h2:    map_type = 3'd5;
            4'hA:    map_type = 3'd6;
            4'hE:    map_type = 3'd7;
            default: mapped   = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            pid_q   <= '0;
            type_q  <= '0;
            exp_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            type_q  <= type_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // Counter stays at zero outside WAIT_DATA, so entry always starts from a clean count.
    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        type_d  = type_q;
        exp_d   = exp_q;
        cnt_d   = '0;
        err_d   = (pid_error || timeout) ? err_q + 8'(err_q != 8'hFF) : err_q;
        case (state_q)
            IDLE: begin
                pid_d   = fifo_empty ? pid_q : fifo_r_data;
                state_d = fifo_empty ? IDLE : DECODE;
            end
            DECODE: begin
                state_d = (chk_ok && mapped) ? ISSUE : IDLE;
                type_d  = (chk_ok && mapped) ? map_type : type_q;
            end
            ISSUE: begin
                state_d = !token_ready ? ISSUE : is_data ? WAIT_DATA : IDLE;
                exp_d   = (token_ready && type_q == 3'd2) ? 1'b0
                        : (token_ready && is_data && !seq_error) ? ~exp_q : exp_q;
            end
            WAIT_DATA: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (data_done || expired) ? IDLE : WAIT_DATA;
            end
        endcase
    end
    always_comb begin
        fifo_r_enable = state_q == IDLE && !fifo_empty && !n_rst;
        token_valid   = state_q == ISSUE;
        token_type    = type_q;
        pid_error     = state_q == DECODE && !chk_ok;
        unsupported   = state_q == DECODE && chk_ok && !mapped;
        seq_error     = accept && is_data && ((type_q == 3'd4) != exp_q);
        timeout       = state_q == WAIT_DATA && expired && !data_done;
        err_count     = err_q;
    end
endmodule
